// File: rtl/prng_arbiter_pkg.sv
// rtl/prng_arbiter_pkg.sv - shared state encoding and helpers for prng_arbiter
//   Exports: ST_* state codes, st_arb_state enum, rr_next() pointer advance.
package prng_arbiter_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_X    = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RUN    = ST_RUN,
    DONE   = ST_DONE,
    STATEX = ST_X
  } st_arb_state;

  // Next round-robin position after index id, wrapping at n requesters.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// rtl/prng_arbiter_if.sv - requester/generator bus of prng_arbiter
//   i_req/i_len/i_seed/i_rdy : per-requester request, burst length, seed, ready
//   o_gnt/o_vld/o_data/o_id/o_last/o_done/o_busy : grant and word stream to owner
//   o_gen_load/o_gen_seed/o_gen_step/i_gen_data : shared generator control/state
//   modport master : arbiter side; modport slave : requesters + generator side
interface prng_arbiter_if
  import prng_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 49,
  parameter int LEN_W      = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*LEN_W-1:0]      i_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_seed;
  logic [NUM_REQ-1:0]            i_rdy;
  logic [NUM_REQ-1:0]            o_gnt;
  logic                          o_vld;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [ID_W-1:0]               o_id;
  logic                          o_last;
  logic                          o_done;
  logic                          o_busy;
  logic                          o_gen_load;
  logic [DATA_WIDTH-1:0]         o_gen_seed;
  logic                          o_gen_step;
  logic [DATA_WIDTH-1:0]         i_gen_data;

  modport master (
    input  i_req, i_len, i_seed, i_rdy, i_gen_data,
    output o_gnt, o_vld, o_data, o_id, o_last, o_done, o_busy,
           o_gen_load, o_gen_seed, o_gen_step
  );

  modport slave (
    output i_req, i_len, i_seed, i_rdy, i_gen_data,
    input  o_gnt, o_vld, o_data, o_id, o_last, o_done, o_busy,
           o_gen_load, o_gen_seed, o_gen_step
  );
endinterface

// File: rtl/prng_arbiter_rr_arbiter.sv
// rtl/prng_arbiter_rr_arbiter.sv - combinational round-robin picker
//   i_req : request vector      i_ptr : highest-priority index
//   o_gnt : one-hot winner      o_id  : encoded winner (0 when no request)
module rr_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_id
);
  logic            found;
  logic [ID_W-1:0] idx;

  // Scan from the pointer upward with wrap; the first set bit wins.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_id       = idx;
      end
    end
  end
endmodule

// File: rtl/prng_arbiter.sv
// rtl/prng_arbiter.sv - round-robin sharing of one LFSR generator among requesters
//   i_clk : clock      i_rst : synchronous active-high reset
//   bus   : prng_arbiter_if.master (requests, word stream, generator control)
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 49,
  parameter int LEN_W      = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  prng_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  st_arb_state           state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  load_q, load_d;
  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [ID_W-1:0]       pick_id;
  logic                  xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .i_req (bus.i_req),
    .i_ptr (ptr_q),
    .o_gnt (pick_gnt),
    .o_id  (pick_id)
  );

  // Reset wins over a pending transfer so an aborted burst never steps the generator.
  assign xfer = (state_q == RUN) & bus.i_rdy[id_q] & ~i_rst;

  // Control outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    gnt_d   = '0;
    load_d  = 1'b0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|bus.i_req) begin
          state_d = LOAD;
          id_d    = pick_id;
          cnt_d   = bus.i_len[int'(pick_id)*LEN_W +: LEN_W];
          seed_d  = bus.i_seed[int'(pick_id)*DATA_WIDTH +: DATA_WIDTH];
          gnt_d   = pick_gnt;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        ptr_d = ID_W'(rr_next(32'(id_q), NUM_REQ));
        if (cnt_q != '0) begin
          state_d = RUN;
          vld_d   = 1'b1;
          last_d  = (cnt_q == LEN_W'(1));
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            vld_d  = 1'b1;
            last_d = (cnt_q == LEN_W'(2));
          end
        end else begin
          vld_d  = 1'b1;
          last_d = last_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_vld      = vld_q;
  assign bus.o_data     = bus.i_gen_data;
  assign bus.o_id       = id_q;
  assign bus.o_last     = last_q;
  assign bus.o_done     = done_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_gen_load = load_q;
  assign bus.o_gen_seed = seed_q;
  assign bus.o_gen_step = xfer;
endmodule

// File: tb/tb_prng_arbiter.sv
// tb/tb_prng_arbiter.sv - self-checking bench for prng_arbiter
module tb_prng_arbiter;
  localparam int NR = 4;
  localparam int DW = 49;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prng_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_W(LW)) bus();

  prng_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] lfsr(input logic [DW-1:0] v);
    return {v[DW-2:0], v[48] ^ v[8]};
  endfunction

  // Generator behind the arbiter: load wins, else step.
  logic [DW-1:0] gen_q = '0;
  assign bus.i_gen_data = gen_q;
  always @(posedge clk) begin
    if (bus.o_gen_load) gen_q <= bus.o_gen_seed;
    else if (bus.o_gen_step) gen_q <= lfsr(gen_q);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event logs filled at every sample point.
  int            gnt_cyc[$];
  int            gnt_id[$];
  int            done_cyc[$];
  logic [DW-1:0] words[$];
  int            last_idx[$];
  int            n_step;
  int            n_vld;

  // Model: 0 waiting, 1 granting, 2 streaming, 3 completing.
  int            m_stage = 0;
  int            m_owner = 0;
  int            m_ptr = 0;
  int            m_left = 0;
  int            m_id = 0;
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] m_seed = '0;
  bit            m_on = 1'b0;

  always @(negedge clk) begin
    logic [NR-1:0] e_gnt;
    logic e_load, e_vld, e_last, e_done, e_busy, e_step;
    if (m_on) begin
      e_gnt = '0; e_load = 0; e_vld = 0; e_last = 0; e_done = 0; e_busy = (m_stage != 0); e_step = 0;
      case (m_stage)
        1: begin e_gnt[m_owner] = 1'b1; e_load = 1'b1; end
        2: begin
          e_vld  = 1'b1;
          e_last = (m_left == 1);
          e_step = bus.i_rdy[m_owner] & ~rst;
          check("data_word", bus.o_data, m_word);
        end
        3: e_done = 1'b1;
        default: ;
      endcase
      check("gnt", bus.o_gnt, e_gnt);
      check("gen_load", bus.o_gen_load, e_load);
      check("vld", bus.o_vld, e_vld);
      check("last", bus.o_last, e_last);
      check("done", bus.o_done, e_done);
      check("busy", bus.o_busy, e_busy);
      check("gen_step", bus.o_gen_step, e_step);
      check("id", bus.o_id, m_id);
      check("gen_seed", bus.o_gen_seed, m_seed);
      check("data_pass", bus.o_data, gen_q);
    end
    if (bus.o_gnt != '0) begin
      gnt_cyc.push_back(cyc);
      for (int i = 0; i < NR; i++) if (bus.o_gnt[i]) gnt_id.push_back(i);
    end
    if (bus.o_vld && bus.i_rdy[bus.o_id]) begin
      words.push_back(bus.o_data);
      if (bus.o_last) last_idx.push_back(words.size());
    end
    if (bus.o_done) done_cyc.push_back(cyc);
    if (bus.o_gen_step) n_step++;
    if (bus.o_vld) n_vld++;
    if (rst) begin
      m_stage = 0; m_ptr = 0; m_id = 0; m_seed = '0; m_on = 1'b1;
    end else if (m_on) begin
      case (m_stage)
        0: if (bus.i_req != '0) begin
          for (int k = NR - 1; k >= 0; k--) if (bus.i_req[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
          m_id   = m_owner;
          m_seed = bus.i_seed[m_owner*DW +: DW];
          m_left = int'(bus.i_len[m_owner*LW +: LW]);
          m_stage = 1;
        end
        1: begin
          m_ptr   = (m_owner + 1) % NR;
          m_word  = m_seed;
          m_stage = (m_left > 0) ? 2 : 3;
        end
        2: if (bus.i_rdy[m_owner]) begin
          m_word = lfsr(m_word);
          m_left--;
          if (m_left == 0) m_stage = 3;
        end
        default: m_stage = 0;
      endcase
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
    bus.i_req = bus.i_req & ~bus.o_gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cyc();
  endtask

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_id.delete(); done_cyc.delete(); words.delete(); last_idx.delete();
    n_step = 0; n_vld = 0;
  endtask

  function automatic int qi(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic logic [DW-1:0] wd(input int k);
    return (k < words.size()) ? words[k] : '1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  int t;
  bit re;
  logic [4:0] pat;

  initial begin
    bus.i_req = '0; bus.i_len = '0; bus.i_seed = '0; bus.i_rdy = '1;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    check("rst_busy", bus.o_busy, 0);
    check("rst_gnt", bus.o_gnt, 0);
    check("rst_id", bus.o_id, 0);
    check("rst_seed", bus.o_gen_seed, 0);
    check("rst_vld", bus.o_vld, 0);

    // single request, len 4, seed 1
    clear_logs();
    bus.i_seed[0*DW +: DW] = 49'h1;
    bus.i_len[0*LW +: LW]  = 8'd4;
    bus.i_req = 4'b0001; t = cyc;
    run(10);
    check("t1_gnt_n", gnt_cyc.size(), 1);
    check("t1_gnt_at", qi(gnt_cyc, 0) - t, 1);
    check("t1_gnt_id", qi(gnt_id, 0), 0);
    check("t1_w0", wd(0), 49'h1);
    check("t1_w1", wd(1), 49'h2);
    check("t1_w2", wd(2), 49'h4);
    check("t1_w3", wd(3), 49'h8);
    check("t1_last_n", last_idx.size(), 1);
    check("t1_last_on", qi(last_idx, 0), 4);
    check("t1_done_at", qi(done_cyc, 0) - t, 6);
    check("t1_steps", n_step, 4);

    // all four request from reset, req0 re-asserted after its burst
    rst = 1'b1; run(1); rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NR; i++) begin
      bus.i_len[i*LW +: LW] = 8'd1;
      bus.i_seed[i*DW +: DW] = DW'((i + 1) * 16);
    end
    bus.i_req = 4'b1111; re = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step_cyc();
      if (!re && bus.o_done) begin bus.i_req[0] = 1'b1; re = 1'b1; end
    end
    check("t2_gnt_n", gnt_id.size(), 5);
    for (int i = 0; i < 5; i++) check("t2_order", qi(gnt_id, i), i % 4);
    check("t2_gap", qi(gnt_cyc, 1) - qi(gnt_cyc, 0), 4);

    // backpressure, owner 2, len 3
    clear_logs();
    bus.i_seed[2*DW +: DW] = 49'h5;
    bus.i_len[2*LW +: LW]  = 8'd3;
    bus.i_req = 4'b0100; t = cyc;
    run(2);
    pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      bus.i_rdy = pat[i] ? 4'b0100 : 4'b1011;
      step_cyc();
    end
    bus.i_rdy = '1;
    run(3);
    check("t3_gnt_id", qi(gnt_id, 0), 2);
    check("t3_w0", wd(0), 49'h5);
    check("t3_w1", wd(1), 49'ha);
    check("t3_w2", wd(2), 49'h14);
    check("t3_steps", n_step, 3);
    check("t3_done_at", qi(done_cyc, 0) - t, 7);

    // zero length, owner 3
    clear_logs();
    bus.i_len[3*LW +: LW] = 8'd0;
    bus.i_req = 4'b1000; t = cyc;
    run(6);
    check("t4_gnt_id", qi(gnt_id, 0), 3);
    check("t4_gnt_at", qi(gnt_cyc, 0) - t, 1);
    check("t4_vld", n_vld, 0);
    check("t4_steps", n_step, 0);
    check("t4_done_at", qi(done_cyc, 0) - t, 2);

    // reset during second word of a len 5 burst
    clear_logs();
    bus.i_seed[0*DW +: DW] = 49'h3;
    bus.i_len[0*LW +: LW]  = 8'd5;
    bus.i_req = 4'b0001;
    run(3);
    rst = 1'b1; run(1); rst = 1'b0;
    check("t5_busy", bus.o_busy, 0);
    check("t5_vld", bus.o_vld, 0);
    check("t5_id", bus.o_id, 0);
    check("t5_seed", bus.o_gen_seed, 0);
    run(3);
    check("t5_no_done", done_cyc.size(), 0);
    check("t5_steps", n_step, 1);
    clear_logs();
    bus.i_len[0*LW +: LW] = 8'd1;
    bus.i_len[1*LW +: LW] = 8'd1;
    bus.i_req = 4'b0011;
    run(12);
    check("t5_ptr0", qi(gnt_id, 0), 0);
    check("t5_next", qi(gnt_id, 1), 1);

    // owner drops request, non-owners toggle ready and request
    clear_logs();
    bus.i_seed[2*DW +: DW] = 49'h1234;
    bus.i_len[2*LW +: LW]  = 8'd3;
    bus.i_len[3*LW +: LW]  = 8'd1;
    bus.i_req = 4'b0100; t = cyc;
    run(2);
    bus.i_req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      bus.i_rdy = (i % 2 == 1) ? 4'b1111 : 4'b0100;
      step_cyc();
    end
    bus.i_rdy = '1;
    check("t6_steps", n_step, 3);
    check("t6_done_at", qi(done_cyc, 0) - t, 5);
    check("t6_w0", wd(0), 49'h1234);
    check("t6_w1", wd(1), 49'h2468);
    check("t6_w2", wd(2), 49'h48d0);
    run(8);
    check("t6_order0", qi(gnt_id, 0), 2);
    check("t6_order1", qi(gnt_id, 1), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
